// File: rtl/netlist_bist_engine.sv
// BIST engine for a combinational netlist: a 14-bit LFSR drives the inputs and
// an 8-bit MISR compacts the responses. The final signature is compared to a golden value.
module netlist_bist_engine #(
   parameter int              IN_W      = 14,
   parameter int              OUT_W     = 8,
   parameter int              PAT_CNT   = 1024,
   parameter logic [IN_W-1:0] LFSR_SEED = 14'h0001,
   parameter logic [OUT_W-1:0] MISR_SEED = 8'h00
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [OUT_W-1:0] golden_sig,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [OUT_W-1:0] signature,
   output logic [14:0]      pat_idx
);

   // An all-zero seed would lock the LFSR up, so it is forced to 1.
   localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
   localparam logic [14:0]     LAST_IDX = 15'(PAT_CNT - 1);

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

   state_t           state_q, state_d;
   logic [IN_W-1:0]  lfsr_q, lfsr_d;
   logic [OUT_W-1:0] misr_q, misr_d;
   logic [14:0]      idx_q, idx_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic [IN_W-1:0]  lfsr_step;
   logic [OUT_W-1:0] misr_step;

   assign lfsr_step = {lfsr_q[12:0], lfsr_q[13] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[0]};
   assign misr_step = {misr_q[6:0], 1'b0} ^ (misr_q[7] ? 8'h1D : 8'h00) ^ dut_out;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      idx_d   = idx_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE, DONE: begin
            if (abort) begin
               state_d = IDLE;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (start) begin
               state_d = RUN;
               lfsr_d  = SEED_EFF;
               misr_d  = MISR_SEED;
               idx_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (abort) begin
               // The partial signature is kept for debug.
               state_d = IDLE;
               lfsr_d  = '0;
            end else begin
               misr_d = misr_step;
               lfsr_d = lfsr_step;
               idx_d  = idx_q + 15'd1;
               if (idx_q == LAST_IDX) begin
                  state_d = CHECK;
                  lfsr_d  = '0;
               end
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
               lfsr_d  = '0;
            end else begin
               pass_d  = (misr_q == golden_sig);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= '0;
         misr_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // The LFSR is cleared whenever RUN is left, so it doubles as the pattern register.
   assign dut_in    = lfsr_q;
   assign signature = misr_q;
   assign pat_idx   = idx_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign busy      = (state_q == RUN) || (state_q == CHECK);

endmodule

// File: tb/tb_netlist_bist_engine.sv
// Scoreboard bench: three engines (PAT_CNT 1, 2, 1024) share clock and reset;
// per-engine monitors pop expected {signature, pass} whenever done rises.
module tb_netlist_bist_engine;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start1 = 0, start2 = 0, start3 = 0, abort3 = 0;
   logic [7:0]  golden1 = 8'hA5, golden2 = 8'hF2, golden3 = 8'h00;
   logic [13:0] dut_in1, dut_in2, dut_in3;
   logic [7:0]  dut_out3, sig1, sig2, sig3;
   logic        busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
   logic [14:0] idx1, idx2, idx3;

   typedef struct {logic [7:0] sig; logic pass;} exp_t;
   exp_t q1[$], q2[$], q3[$];
   int tests = 0, fails = 0;
   logic prev1 = 0, prev2 = 0, prev3 = 0;

   always #5 clk = ~clk;

   // Reference "benchmark netlist" feeding the long-run engine.
   function automatic logic [7:0] net(input logic [13:0] x);
      return x[7:0] ^ {x[13:8], x[1:0]} ^ ({x[5:0], x[13:12]} & x[11:4]);
   endfunction

   function automatic logic [7:0] sig_model(input int n);
      logic [13:0] l = 14'h0001;
      logic [7:0]  m = 8'h00;
      for (int i = 0; i < n; i++) begin
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ net(l);
         l = {l[12:0], l[13] ^ l[4] ^ l[2] ^ l[0]};
      end
      return m;
   endfunction

   assign dut_out3 = net(dut_in3);

   netlist_bist_engine #(.PAT_CNT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .golden_sig(golden1),
      .dut_in(dut_in1), .dut_out(8'hA5), .busy(busy1), .done(done1), .pass(pass1),
      .signature(sig1), .pat_idx(idx1));
   netlist_bist_engine #(.PAT_CNT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .golden_sig(golden2),
      .dut_in(dut_in2), .dut_out(8'hA5), .busy(busy2), .done(done2), .pass(pass2),
      .signature(sig2), .pat_idx(idx2));
   netlist_bist_engine #(.PAT_CNT(1024)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .golden_sig(golden3),
      .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
      .signature(sig3), .pat_idx(idx3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done1 && !prev1) begin
         if (q1.size() == 0) chk("mon1 unexpected done", 1, 0);
         else begin e = q1.pop_front(); chk("mon1 sig", sig1, e.sig); chk("mon1 pass", pass1, e.pass); end
      end
      prev1 = done1;
   end
   always @(negedge clk) begin
      exp_t e;
      if (done2 && !prev2) begin
         if (q2.size() == 0) chk("mon2 unexpected done", 1, 0);
         else begin e = q2.pop_front(); chk("mon2 sig", sig2, e.sig); chk("mon2 pass", pass2, e.pass); end
      end
      prev2 = done2;
   end
   always @(negedge clk) begin
      exp_t e;
      if (done3 && !prev3) begin
         if (q3.size() == 0) chk("mon3 unexpected done", 1, 0);
         else begin e = q3.pop_front(); chk("mon3 sig", sig3, e.sig); chk("mon3 pass", pass3, e.pass); end
      end
      prev3 = done3;
   end

   task automatic wait_done3(input string name);
      int n = 0;
      while (!done3 && n < 2000) begin @(negedge clk); n++; end
      if (!done3) chk({name, " done timeout"}, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] full;
      int n;
      full = sig_model(1024);
      golden3 = full;
      repeat (2) @(negedge clk);
      chk("rst dut_in", dut_in3, 0);  chk("rst sig", sig3, 0);   chk("rst idx", idx3, 0);
      chk("rst busy", busy3, 0);      chk("rst done", done3, 0); chk("rst pass", pass3, 0);
      rst_n = 1'b1;

      // PAT_CNT=1: one pattern of 0x0001, done/pass on the third edge counting the start edge
      q1.push_back('{8'hA5, 1'b1});
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      chk("p1 dut_in run", dut_in1, 14'h0001); chk("p1 busy run", busy1, 1);
      @(negedge clk);
      chk("p1 dut_in check", dut_in1, 0); chk("p1 done early", done1, 0); chk("p1 busy check", busy1, 1);
      @(negedge clk);
      chk("p1 done", done1, 1); chk("p1 busy done", busy1, 0);

      // PAT_CNT=2: patterns 0x0001, 0x0003; signature 0xF2, then a mismatching golden
      q2.push_back('{8'hF2, 1'b1});
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      chk("p2 dut_in 0", dut_in2, 14'h0001);
      @(negedge clk) chk("p2 dut_in 1", dut_in2, 14'h0003);
      @(negedge clk) chk("p2 dut_in check", dut_in2, 0);
      @(negedge clk) chk("p2 done", done2, 1);
      golden2 = 8'hF3;
      q2.push_back('{8'hF2, 1'b0});
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      chk("p2 restart clears done", done2, 0);
      repeat (3) @(negedge clk);
      chk("p2 rerun done", done2, 1);

      // PAT_CNT=1024 against the reference netlist; busy must last 1025 cycles
      q3.push_back('{full, 1'b1});
      @(negedge clk) start3 = 1;
      @(negedge clk) start3 = 0;
      n = 0;
      while (busy3 && n < 2000) begin n++; @(negedge clk); end
      chk("p3 busy cycles", n, 1025);
      chk("p3 done", done3, 1);

      // abort at pat_idx 5, then rerun from seed
      @(negedge clk) start3 = 1;
      @(negedge clk) start3 = 0;
      n = 0;
      while (idx3 != 15'd5 && n < 50) begin @(negedge clk); n++; end
      chk("abort reach idx5", idx3, 5);
      abort3 = 1;
      @(negedge clk) abort3 = 0;
      chk("abort busy", busy3, 0); chk("abort dut_in", dut_in3, 0);
      chk("abort done", done3, 0); chk("abort partial sig", sig3, sig_model(5));
      @(negedge clk) chk("abort stays idle", busy3, 0);
      q3.push_back('{full, 1'b1});
      start3 = 1;
      @(negedge clk) start3 = 0;
      wait_done3("rerun");

      // asynchronous reset mid-run; no done may follow
      @(negedge clk) start3 = 1;
      @(negedge clk) start3 = 0;
      repeat (20) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("arst dut_in", dut_in3, 0); chk("arst sig", sig3, 0);   chk("arst idx", idx3, 0);
      chk("arst busy", busy3, 0);     chk("arst done", done3, 0); chk("arst pass", pass3, 0);
      @(negedge clk) rst_n = 1'b1;
      q3.push_back('{full, 1'b1});
      @(negedge clk) start3 = 1;
      @(negedge clk) start3 = 0;
      chk("post-rst busy", busy3, 1); chk("post-rst dut_in", dut_in3, 14'h0001);
      wait_done3("post-rst");

      // start held high through a whole run: ignored while busy, restarts from DONE
      q3.push_back('{full, 1'b1});
      q3.push_back('{full, 1'b1});
      @(negedge clk) start3 = 1;
      @(negedge clk);
      repeat (10) @(negedge clk);
      chk("held start ignored idx", idx3, 10);
      wait_done3("held");
      @(negedge clk);
      chk("held done 1 cycle", done3, 0); chk("held pass cleared", pass3, 0);
      chk("held restart busy", busy3, 1); chk("held restart idx", idx3, 0);
      start3 = 0;
      wait_done3("held second");

      repeat (2) @(negedge clk);
      chk("scoreboard drained", q1.size() + q2.size() + q3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
